seq_det_ctrl: RTL and testbench

//  Run controller for the 4-bit Moore serial sequence detector.
//  - Accepts a pattern/target/timeout config via valid/ready handshake.
//  - Loads the pattern into the detector and flushes it with a reset window.
//  - Gates the bit stream, counts detected matches, ends on target count or timeout.
//  - Sits between the config/status interface and one detector instance.

---
 rtl/seq_det_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Run controller for a 4-bit Moore serial sequence detector.
// Loads config, flushes the detector, counts matches, ends on target/timeout.
module seq_det_ctrl #(
  parameter int PAT_W     = 4,
  parameter int CNT_W     = 8,
  parameter int TO_W      = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [CNT_W-1:0] cfg_target_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             bit_valid_i,
  input  logic             det_match_i,
  output logic [PAT_W-1:0] det_pattern_o,
  output logic             det_rst_o,
  output logic             det_en_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int FL_W = $clog2(FLUSH_CYC);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [TO_W-1:0]  lim_q, lim_d;
  logic             loaded_q, loaded_d;
  logic [FL_W-1:0]  fcnt_q, fcnt_d;
  logic [TO_W-1:0]  bcnt_q, bcnt_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rdy_q, rdy_d;
  logic [PAT_W-1:0] dpat_q, dpat_d;
  logic             drst_q, drst_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;

  logic [CNT_W-1:0] tgt_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [TO_W-1:0]  bcnt_inc;
  logic             rise;
  logic             hit_tgt;
  logic             hit_to;
  logic             cfg_fire;
  logic             fin;

  assign tgt_eff  = (tgt_q == '0) ? CNT_W'(1) : tgt_q;
  assign cnt_inc  = cnt_q + 1'b1;
  assign bcnt_inc = bcnt_q + 1'b1;
  assign rise     = det_match_i & ~prev_q;
  assign hit_tgt  = rise && (cnt_inc == tgt_eff);
  assign hit_to   = bit_valid_i && (lim_q != '0) && (bcnt_inc == lim_q);
  assign cfg_fire = cfg_valid_i && (state_q == IDLE);
  assign fin      = (state_q == RUN) && (state_d == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      tgt_q    <= '0;
      lim_q    <= '0;
      loaded_q <= 1'b0;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
      dpat_q   <= '0;
      drst_q   <= 1'b1;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      tgt_q    <= tgt_d;
      lim_q    <= lim_d;
      loaded_q <= loaded_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      dpat_q   <= dpat_d;
      drst_q   <= drst_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
    end
  end

  // abort outranks both flush completion and end-of-run events
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i && loaded_q) state_d = FLUSH;
      FLUSH: begin
        if (abort_i)                state_d = IDLE;
        else if (fcnt_q == FL_LAST) state_d = RUN;
      end
      RUN: begin
        if (abort_i)                state_d = IDLE;
        else if (hit_tgt || hit_to) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_d    = pat_q;
    tgt_d    = tgt_q;
    lim_d    = lim_q;
    loaded_d = loaded_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    dpat_d   = dpat_q;
    if (cfg_fire) begin
      pat_d    = cfg_pattern_i;
      tgt_d    = cfg_target_i;
      lim_d    = cfg_timeout_i;
      loaded_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (state_d == FLUSH) begin
          cnt_d  = '0;
          bcnt_d = '0;
          fcnt_d = '0;
          dpat_d = pat_q;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        prev_d = 1'b0;
      end
      RUN: begin
        if (!abort_i) begin
          prev_d = det_match_i;
          if (rise)        cnt_d  = cnt_inc;
          if (bit_valid_i) bcnt_d = bcnt_inc;
        end
      end
      default: ;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d == FLUSH) || (state_d == RUN);
    drst_d = (state_d != RUN);
    en_d   = (state_d == RUN);
    done_d = fin && hit_tgt;
    tout_d = fin && !hit_tgt;
  end

  assign cfg_ready_o   = rdy_q;
  assign det_pattern_o = dpat_q;
  assign det_rst_o     = drst_q;
  assign det_en_o      = en_q & bit_valid_i;
  assign match_cnt_o   = cnt_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = tout_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a behavioural 4-bit Moore detector.
// Expected values are hand-derived per scenario.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_pattern = '0;
  logic [7:0] cfg_target = '0;
  logic [15:0] cfg_timeout = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       det_match;
  logic [3:0] det_pattern;
  logic       det_rst;
  logic       det_en;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       frc = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_to = 0;
  int d0, t0;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_pattern_i (cfg_pattern),
    .cfg_target_i  (cfg_target),
    .cfg_timeout_i (cfg_timeout),
    .start_i       (start),
    .abort_i       (abort),
    .bit_valid_i   (bit_valid),
    .det_match_i   (det_match),
    .det_pattern_o (det_pattern),
    .det_rst_o     (det_rst),
    .det_en_o      (det_en),
    .match_cnt_o   (match_cnt),
    .busy_o        (busy),
    .done_o        (done),
    .timeout_o     (timeout)
  );

  logic [3:0] sr = '0;
  logic [2:0] fill = '0;
  logic       mdl = 1'b0;

  // overlapping Moore detector: output reflects the last 4 accepted bits
  always @(posedge clk) begin
    if (det_rst) begin
      sr   <= '0;
      fill <= '0;
      mdl  <= 1'b0;
    end else if (det_en) begin
      sr  <= {sr[2:0], bit_in};
      if (fill != 3'd4) fill <= fill + 3'd1;
      mdl <= ({sr[2:0], bit_in} == det_pattern) && (fill >= 3'd3);
    end
  end

  assign det_match = frc ? 1'b1 : mdl;

  always @(negedge clk) begin
    if (done)    n_done++;
    if (timeout) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [3:0] p, input logic [7:0] t,
                          input logic [15:0] to);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    cfg_target  = t;
    cfg_timeout = to;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic run_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = v[i];
      cyc();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit_valid = 1'b1;
    cyc();
    cyc();
    check("rst_ready", cfg_ready, 1);
    check("rst_pat", det_pattern, 0);
    check("rst_drst", det_rst, 1);
    check("rst_en", det_en, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_to", timeout, 0);
    bit_valid = 1'b0;
    rst = 1'b0;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check("nocfg_busy", busy, 0);

    d0 = n_done;
    t0 = n_to;
    load_cfg(4'b1011, 8'd2, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("b_busy", busy, 1);
    check("b_ready", cfg_ready, 0);
    check("b_pat", det_pattern, 4'b1011);
    check("b_drst1", det_rst, 1);
    cyc();
    check("b_drst2", det_rst, 1);
    cyc();
    check("b_drst_run", det_rst, 0);
    run_bits(16'b1011, 4);
    check("b_cnt0", match_cnt, 0);
    run_bits(16'b0, 1);
    check("b_cnt1", match_cnt, 1);
    run_bits(16'b1011, 4);
    check("b_cnt1b", match_cnt, 1);
    check("b_nodone", done, 0);
    bit_valid = 1'b1;
    cyc();
    check("b_done", done, 1);
    check("b_cnt2", match_cnt, 2);
    check("b_fin_busy", busy, 0);
    check("b_fin_en", det_en, 0);
    check("b_fin_drst", det_rst, 1);
    bit_valid = 1'b0;
    cyc();
    check("b_idle_ready", cfg_ready, 1);
    check("b_done_off", done, 0);
    check("b_cnt_hold", match_cnt, 2);
    check("b_ndone", n_done - d0, 1);
    check("b_nto", n_to - t0, 0);

    d0 = n_done;
    t0 = n_to;
    load_cfg(4'b1011, 8'd3, 16'd8);
    start_run();
    run_bits(16'b0, 7);
    check("t_busy7", busy, 1);
    check("t_to7", timeout, 0);
    run_bits(16'b0, 1);
    check("t_to", timeout, 1);
    check("t_done", done, 0);
    check("t_cnt", match_cnt, 0);
    check("t_busy", busy, 0);
    cyc();
    check("t_ready", cfg_ready, 1);
    check("t_to_off", timeout, 0);
    check("t_nto", n_to - t0, 1);
    check("t_ndone", n_done - d0, 0);

    d0 = n_done;
    t0 = n_to;
    load_cfg(4'b1011, 8'd1, 16'd4);
    start_run();
    run_bits(16'b101, 3);
    frc       = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    cyc();
    frc       = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("s_done", done, 1);
    check("s_to", timeout, 0);
    check("s_cnt", match_cnt, 1);
    cyc();
    check("s_ndone", n_done - d0, 1);
    check("s_nto", n_to - t0, 0);

    d0 = n_done;
    t0 = n_to;
    load_cfg(4'b1011, 8'd2, 16'd0);
    start_run();
    run_bits(16'b1011, 4);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("a_busy", busy, 0);
    check("a_ready", cfg_ready, 1);
    check("a_drst", det_rst, 1);
    check("a_cnt", match_cnt, 0);
    cyc();
    check("a_ndone", n_done - d0, 0);
    check("a_nto", n_to - t0, 0);

    load_cfg(4'b1011, 8'd2, 16'd0);
    start_run();
    cfg_valid   = 1'b1;
    cfg_pattern = 4'b0110;
    cfg_target  = 8'd1;
    cyc();
    check("h_ready_run", cfg_ready, 0);
    check("h_pat_run", det_pattern, 4'b1011);
    cfg_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("h_shadow", det_pattern, 4'b1011);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cfg_valid   = 1'b1;
    cfg_pattern = 4'b0110;
    check("h_ready_idle", cfg_ready, 1);
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("h_newpat", det_pattern, 4'b0110);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    load_cfg(4'b1011, 8'd2, 16'd0);
    start_run();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("r_busy", busy, 0);
    check("r_drst", det_rst, 1);
    check("r_pat", det_pattern, 0);
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check("r_noload", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
